// File: rtl/dnn_dot_accel.sv
`default_nettype none
// ============================================================================
// Module   : dnn_dot_accel
// Brief    : Single-neuron dot-product accelerator. CPU programs addresses
//            and length over an Avalon-MM slave; the block fetches bias,
//            weights and activations over an Avalon-MM master, accumulates
//            bias + sum(w[i]*a[i]) in signed Q16.16 and writes the result.
//            Optional macro DNN_RELU_EN adds a ReLU enable at offset 7.
// Revision : 1.0 - initial release
// ============================================================================
module dnn_dot_accel #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic [31:0]       slave_readdata,
    output logic              slave_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [31:0]       master_writedata,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_waitrequest
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_BIAS = 4'd1,
        ST_WT_BIAS = 4'd2,
        ST_RD_W    = 4'd3,
        ST_WT_W    = 4'd4,
        ST_RD_A    = 4'd5,
        ST_WT_A    = 4'd6,
        ST_MAC     = 4'd7,
        ST_WR_OUT  = 4'd8
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] bias_addr_q;
    logic [ADDR_W-1:0] w_base_q;
    logic [ADDR_W-1:0] a_base_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [LEN_W-1:0]  n_q;
    logic [LEN_W-1:0]  idx_q;
    logic [31:0]       acc_q;
    logic [31:0]       w_q;
    logic [31:0]       a_q;
    logic [31:0]       readdata_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic              m_read_q;
    logic              m_write_q;
    logic [31:0]       m_wdata_q;
`ifdef DNN_RELU_EN
    logic              relu_q;
`endif

    logic              idle_d;
    logic              slv_wait_d;
    logic              cfg_wr_d;
    logic              start_d;
    logic [LEN_W-1:0]  idx_inc_d;
    logic [63:0]       w_ext_d;
    logic [63:0]       a_ext_d;
    logic [31:0]       acc_mac_d;

    assign idle_d     = (state_q == ST_IDLE);
    // Only a status read while busy stalls; everything else completes at once.
    assign slv_wait_d = slave_read && (slave_address == 4'd0) && !idle_d;
    assign cfg_wr_d   = slave_write && idle_d;
    assign start_d    = cfg_wr_d && (slave_address == 4'd0);
    assign idx_inc_d  = idx_q + LEN_W'(1);

    // Sign-extended operands; low 64 bits of the product equal the 32x32 signed product.
    assign w_ext_d   = {{32{w_q[31]}}, w_q};
    assign a_ext_d   = {{32{a_q[31]}}, a_q};
    assign acc_mac_d = acc_q + 32'((w_ext_d * a_ext_d) >> 16);

    assign slave_waitrequest = slv_wait_d;
    assign slave_readdata    = readdata_q;
    assign master_address    = m_addr_q;
    assign master_read       = m_read_q;
    assign master_write      = m_write_q;
    assign master_writedata  = m_wdata_q;

    function automatic logic [ADDR_W-1:0] word_off(input logic [LEN_W-1:0] i);
        return ADDR_W'(i) << 2;
    endfunction

    function automatic logic [31:0] post_act(input logic [31:0] v);
`ifdef DNN_RELU_EN
        return (relu_q && v[31]) ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    // Configuration registers, writable only while idle.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            bias_addr_q <= '0;
            w_base_q    <= '0;
            a_base_q    <= '0;
            out_addr_q  <= '0;
            n_q         <= '0;
`ifdef DNN_RELU_EN
            relu_q      <= 1'b0;
`endif
        end else if (cfg_wr_d) begin
            case (slave_address)
                4'd1:    bias_addr_q <= ADDR_W'(slave_writedata);
                4'd2:    w_base_q    <= ADDR_W'(slave_writedata);
                4'd3:    a_base_q    <= ADDR_W'(slave_writedata);
                4'd4:    out_addr_q  <= ADDR_W'(slave_writedata);
                4'd5:    n_q         <= slave_writedata[LEN_W-1:0];
`ifdef DNN_RELU_EN
                4'd7:    relu_q      <= slave_writedata[0];
`endif
                default: ;
            endcase
        end
    end

    // Slave read data, returned the cycle after an accepted read.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            readdata_q <= '0;
        end else if (slave_read && !slv_wait_d) begin
            case (slave_address)
                4'd1:    readdata_q <= 32'(bias_addr_q);
                4'd2:    readdata_q <= 32'(w_base_q);
                4'd3:    readdata_q <= 32'(a_base_q);
                4'd4:    readdata_q <= 32'(out_addr_q);
                4'd5:    readdata_q <= 32'(n_q);
`ifdef DNN_RELU_EN
                4'd7:    readdata_q <= {31'd0, relu_q};
`endif
                default: readdata_q <= '0;
            endcase
        end
    end

    // Sequencer: fetch bias, then per element fetch w and a and MAC, then write.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            w_q       <= '0;
            a_q       <= '0;
            m_addr_q  <= '0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        idx_q    <= '0;
                        acc_q    <= '0;
                        m_read_q <= 1'b1;
                        m_addr_q <= bias_addr_q;
                        state_q  <= ST_RD_BIAS;
                    end
                end
                ST_RD_BIAS: begin
                    if (!master_waitrequest) begin
                        m_read_q <= 1'b0;
                        state_q  <= ST_WT_BIAS;
                    end
                end
                ST_WT_BIAS: begin
                    if (master_readdatavalid) begin
                        acc_q <= master_readdata;
                        if (n_q == '0) begin
                            m_write_q <= 1'b1;
                            m_addr_q  <= out_addr_q;
                            m_wdata_q <= post_act(master_readdata);
                            state_q   <= ST_WR_OUT;
                        end else begin
                            m_read_q <= 1'b1;
                            m_addr_q <= w_base_q + word_off(idx_q);
                            state_q  <= ST_RD_W;
                        end
                    end
                end
                ST_RD_W: begin
                    if (!master_waitrequest) begin
                        m_read_q <= 1'b0;
                        state_q  <= ST_WT_W;
                    end
                end
                ST_WT_W: begin
                    if (master_readdatavalid) begin
                        w_q      <= master_readdata;
                        m_read_q <= 1'b1;
                        m_addr_q <= a_base_q + word_off(idx_q);
                        state_q  <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    if (!master_waitrequest) begin
                        m_read_q <= 1'b0;
                        state_q  <= ST_WT_A;
                    end
                end
                ST_WT_A: begin
                    if (master_readdatavalid) begin
                        a_q     <= master_readdata;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_mac_d;
                    if (idx_inc_d == n_q) begin
                        m_write_q <= 1'b1;
                        m_addr_q  <= out_addr_q;
                        m_wdata_q <= post_act(acc_mac_d);
                        state_q   <= ST_WR_OUT;
                    end else begin
                        idx_q    <= idx_inc_d;
                        m_read_q <= 1'b1;
                        m_addr_q <= w_base_q + word_off(idx_inc_d);
                        state_q  <= ST_RD_W;
                    end
                end
                ST_WR_OUT: begin
                    if (!master_waitrequest) begin
                        m_write_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dnn_dot_accel.sv
`default_nettype none
// ============================================================================
// Module   : tb_dnn_dot_accel
// Brief    : Self-checking bench for dnn_dot_accel: SDRAM model with
//            programmable wait states and read latency, vector table,
//            randomized jobs against a Q16.16 reference, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dnn_dot_accel;

    localparam logic [31:0] BIAS_A = 32'h0000_0040;
    localparam logic [31:0] WB_A   = 32'h0000_0100;
    localparam logic [31:0] AB_A   = 32'h0000_0200;
    localparam logic [31:0] OUT_A  = 32'h0000_0300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_addr;
    logic        s_rd;
    logic        s_wr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        s_wait;
    logic [31:0] m_addr;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_rdv;
    logic        m_wait;

    always #5 clk = ~clk;

    dnn_dot_accel #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk_clk              (clk),
        .reset_reset_n        (rst_n),
        .slave_address        (s_addr),
        .slave_read           (s_rd),
        .slave_write          (s_wr),
        .slave_writedata      (s_wdata),
        .slave_readdata       (s_rdata),
        .slave_waitrequest    (s_wait),
        .master_address       (m_addr),
        .master_read          (m_rd),
        .master_write         (m_wr),
        .master_writedata     (m_wdata),
        .master_readdata      (m_rdata),
        .master_readdatavalid (m_rdv),
        .master_waitrequest   (m_wait)
    );

    int total = 0;
    int bad   = 0;

    // SDRAM model state
    logic [31:0] mem [0:255];
    int          ws_cfg = 0;
    int          rd_lat = 1;
    int          wcnt = 0;
    int          pend = 0;
    logic [31:0] pend_data = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          stab_err = 0;
    int          cyc = 0;
    int          wr_cyc = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        hold = 1'b0;
    logic [31:0] hold_addr = '0;

    assign m_wait  = (m_rd | m_wr) && (wcnt < ws_cfg);
    assign m_rdv   = (pend == 1);
    assign m_rdata = pend_data;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pend != 0) pend <= pend - 1;
        if ((m_rd | m_wr) && m_wait) begin
            wcnt      <= wcnt + 1;
            hold      <= 1'b1;
            hold_addr <= m_addr;
        end else begin
            wcnt <= 0;
            hold <= 1'b0;
        end
        if (hold && (!(m_rd | m_wr) || m_addr != hold_addr)) stab_err <= stab_err + 1;
        if (m_rd && !m_wait) begin
            rd_cnt    <= rd_cnt + 1;
            pend      <= rd_lat;
            pend_data <= mem[m_addr[9:2]];
        end
        if (m_wr && !m_wait) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= m_addr;
            wr_data <= m_wdata;
            wr_cyc  <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d, output int c);
        @(negedge clk);
        s_addr  = a;
        s_wdata = d;
        s_wr    = 1'b1;
        @(negedge clk);
        s_wr = 1'b0;
        c    = cyc;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int waited);
        @(negedge clk);
        s_addr = a;
        s_rd   = 1'b1;
        waited = 0;
        #1;
        while (s_wait && waited < 3000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        s_rd = 1'b0;
        d    = s_rdata;
    endtask

    task automatic wait_write(input int w0, input string nm);
        int k = 0;
        while (wr_cnt == w0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " done-in-time"}, 32'(k < 5000), 32'd1);
    endtask

    task automatic load_mem(input int n, input logic [31:0] bias,
                            input logic [7:0][31:0] w, input logic [7:0][31:0] a,
                            input logic [31:0] wbase);
        logic [31:0] ad;
        ad = BIAS_A;
        mem[ad[9:2]] = bias;
        for (int i = 0; i < n; i++) begin
            ad = wbase + 32'(4 * i);
            mem[ad[9:2]] = w[i];
            ad = AB_A + 32'(4 * i);
            mem[ad[9:2]] = a[i];
        end
    endtask

    task automatic program_regs(input int n, input logic [31:0] wbase, input bit relu);
        int c;
        cpu_write(4'd1, BIAS_A, c);
        cpu_write(4'd2, wbase, c);
        cpu_write(4'd3, AB_A, c);
        cpu_write(4'd4, OUT_A, c);
        cpu_write(4'd5, 32'(n), c);
        cpu_write(4'd7, {31'd0, relu}, c);
    endtask

    task automatic run_job(input string nm, input int n, input logic [31:0] bias,
                           input logic [7:0][31:0] w, input logic [7:0][31:0] a,
                           input logic [31:0] wbase, input bit relu, input int ws,
                           input logic [31:0] exp);
        int c0, r0, w0, s0, waited;
        logic [31:0] d;
        ws_cfg = ws;
        rd_lat = 1;
        load_mem(n, bias, w, a, wbase);
        program_regs(n, wbase, relu);
        r0 = rd_cnt;
        w0 = wr_cnt;
        s0 = stab_err;
        cpu_write(4'd0, 32'd1, c0);
        wait_write(w0, nm);
        @(negedge clk);
        chk({nm, " result"}, wr_data, exp);
        chk({nm, " out-addr"}, wr_addr, OUT_A);
        chk({nm, " writes"}, 32'(wr_cnt - w0), 32'd1);
        chk({nm, " reads"}, 32'(rd_cnt - r0), 32'(1 + 2 * n));
        chk({nm, " addr-stable"}, 32'(stab_err - s0), 32'd0);
        if (ws == 0) chk({nm, " latency"}, 32'(wr_cyc - c0 + 1), 32'(3 + 5 * n));
        cpu_read(4'd0, d, waited);
        chk({nm, " status-read"}, d, 32'd0);
    endtask

    // Reference: bias + sum(floor(w*a / 2^16)) modulo 2^32, optional ReLU.
    function automatic logic [31:0] model(input int n, input logic [31:0] bias,
                                          input logic [7:0][31:0] w,
                                          input logic [7:0][31:0] a, input bit relu);
        longint p;
        logic [31:0] acc;
        acc = bias;
        for (int i = 0; i < n; i++) begin
            p   = longint'($signed(w[i])) * longint'($signed(a[i]));
            acc = acc + 32'(p >>> 16);
        end
`ifdef DNN_RELU_EN
        if (relu && acc[31]) acc = 32'd0;
`else
        if (relu) acc = acc;
`endif
        return acc;
    endfunction

    typedef struct {
        string           nm;
        int              n;
        logic [31:0]     bias;
        logic [7:0][31:0] w;
        logic [7:0][31:0] a;
        logic [31:0]     wbase;
        bit              relu;
        int              ws;
        logic [31:0]     exp;
    } vec_t;

    function automatic vec_t mk(input string nm, input int n, input logic [31:0] bias,
                                input logic [31:0] wbase, input bit relu, input int ws,
                                input logic [31:0] exp);
        vec_t v;
        v.nm = nm; v.n = n; v.bias = bias; v.w = '0; v.a = '0;
        v.wbase = wbase; v.relu = relu; v.ws = ws; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        logic [31:0] d;
        logic [31:0] relu_exp;
        logic [7:0][31:0] rw;
        logic [7:0][31:0] ra;
        int waited, c, r0, w0, k, rn;
        bit rr;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n = 1'b0; s_addr = '0; s_rd = 1'b0; s_wr = 1'b0; s_wdata = '0;

`ifdef DNN_RELU_EN
        relu_exp = 32'h0000_0000;
`else
        relu_exp = 32'hFFFF_0000;
`endif
        tbl[0] = mk("n1", 1, 32'h0001_0000, WB_A, 1'b0, 0, 32'h0004_0000);
        tbl[0].w[0] = 32'h0002_0000; tbl[0].a[0] = 32'h0001_8000;
        tbl[1] = mk("n0", 0, 32'hFFFF_0000, WB_A, 1'b0, 0, 32'hFFFF_0000);
        tbl[2] = mk("n3", 3, 32'h0, WB_A, 1'b0, 0, 32'h0003_0000);
        tbl[2].w[0] = 32'h0001_0000; tbl[2].w[1] = 32'hFFFE_0000; tbl[2].w[2] = 32'h0000_8000;
        tbl[2].a[0] = 32'h0004_0000; tbl[2].a[1] = 32'h0001_0000; tbl[2].a[2] = 32'h0002_0000;
        tbl[3] = tbl[2]; tbl[3].nm = "n3-ws3"; tbl[3].ws = 3;
        tbl[4] = mk("acc-wrap", 1, 32'h7FFF_0000, WB_A, 1'b0, 0, 32'h8000_0000);
        tbl[4].w[0] = 32'h0001_0000; tbl[4].a[0] = 32'h0001_0000;
        tbl[5] = mk("trunc", 2, 32'h5, WB_A, 1'b0, 0, 32'h0000_0004);
        tbl[5].w[0] = 32'h1; tbl[5].w[1] = 32'hFFFF_FFFF; tbl[5].a[0] = 32'h1; tbl[5].a[1] = 32'h1;
        tbl[6] = mk("addr-wrap", 4, 32'h0, 32'hFFFF_FFF8, 1'b0, 1, 32'h000A_0000);
        for (int i = 0; i < 4; i++) begin
            tbl[6].w[i] = 32'h0001_0000;
            tbl[6].a[i] = 32'(i + 1) << 16;
        end
        tbl[7] = mk("relu1", 1, 32'h0, WB_A, 1'b1, 0, relu_exp);
        tbl[7].w[0] = 32'hFFFF_0000; tbl[7].a[0] = 32'h0001_0000;
        tbl[8] = tbl[7]; tbl[8].nm = "relu0"; tbl[8].relu = 1'b0; tbl[8].exp = 32'hFFFF_0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst master_read", 32'(m_rd), 32'd0);
        chk("rst master_write", 32'(m_wr), 32'd0);
        chk("rst master_address", m_addr, 32'd0);
        chk("rst master_writedata", m_wdata, 32'd0);
        chk("rst slave_waitrequest", 32'(s_wait), 32'd0);
        chk("rst slave_readdata", s_rdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_job(tbl[i].nm, tbl[i].n, tbl[i].bias, tbl[i].w, tbl[i].a,
                    tbl[i].wbase, tbl[i].relu, tbl[i].ws, tbl[i].exp);

        // Randomized jobs against the reference model
        for (int t = 0; t < 12; t++) begin
            rn = $urandom_range(0, 6);
            rr = 1'($urandom_range(0, 1));
            rw = '0; ra = '0;
            for (int i = 0; i < rn; i++) begin
                rw[i] = $urandom;
                ra[i] = $urandom;
            end
            d = $urandom;
            run_job("rand", rn, d, rw, ra, WB_A, rr, $urandom_range(0, 2), model(rn, d, rw, ra, rr));
        end

        // Config writes while busy are ignored; status read stalls until idle
        ws_cfg = 2; rd_lat = 1;
        load_mem(3, 32'h0, tbl[2].w, tbl[2].a, WB_A);
        program_regs(3, WB_A, 1'b0);
        w0 = wr_cnt;
        cpu_write(4'd0, 32'd1, c);
        cpu_write(4'd2, 32'h0000_0180, c);
        cpu_write(4'd5, 32'd1, c);
        cpu_read(4'd0, d, waited);
        chk("busy stall-seen", 32'(waited > 0 && waited < 3000), 32'd1);
        chk("busy status-read", d, 32'd0);
        chk("busy done-at-release", 32'(wr_cnt - w0), 32'd1);
        chk("busy result", wr_data, 32'h0003_0000);
        cpu_read(4'd2, d, waited);
        chk("busy wbase-kept", d, WB_A);
        cpu_read(4'd5, d, waited);
        chk("busy n-kept", d, 32'd3);

        // Reset while waiting for weight data (long read latency)
        ws_cfg = 0; rd_lat = 4;
        load_mem(2, 32'h0, tbl[2].w, tbl[2].a, WB_A);
        program_regs(2, WB_A, 1'b0);
        r0 = rd_cnt; w0 = wr_cnt;
        cpu_write(4'd0, 32'd1, c);
        k = 0;
        while (!(rd_cnt == r0 + 2 && !m_rd) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rst-wt_w reached", 32'(k < 200), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst-wt_w master_read", 32'(m_rd), 32'd0);
        chk("rst-wt_w master_write", 32'(m_wr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst-wt_w no-write", 32'(wr_cnt - w0), 32'd0);
        cpu_read(4'd0, d, waited);
        chk("rst-wt_w idle", 32'(waited), 32'd0);
        cpu_read(4'd1, d, waited);
        chk("rst-wt_w regs-cleared", d, 32'd0);

        // Reset while a bias read is held off by waitrequest
        ws_cfg = 20; rd_lat = 1;
        program_regs(2, WB_A, 1'b0);
        cpu_write(4'd0, 32'd1, c);
        @(negedge clk);
        @(negedge clk);
        chk("rst-stall read-held", 32'(m_rd), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst-stall master_read", 32'(m_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Fresh job after reset completes correctly
        run_job("post-reset", 3, 32'h0, tbl[2].w, tbl[2].a, WB_A, 1'b0, 0, 32'h0003_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
